cdb_bcast: RTL

- Common-data-bus broadcaster: transmit side of the wakeup protocol consumed by every reservation-station entry and the ROB.
- Collects completed results from NUM_FU functional units into one holding slot per FU.
- Round-robin arbitrates; drives at most one {valid, dest tag, ROB index, branch mask} per cycle.
- Squashes and fixes pending results on branch recovery and correct prediction, using the same tag-fix semantics as the RS.

---
 rtl/cdb_bcast_if.sv | 33 +++
 rtl/cdb_bcast.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdb_bcast_if.sv
// FU completion, branch-resolution and CDB broadcast signals for cdb_bcast.
// slave is the broadcaster side; master is the FU/branch-unit side.
interface cdb_bcast_if #(
  parameter int NUM_FU    = 4,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5
);
  logic [NUM_FU-1:0]           fu_vld_i;
  logic [NUM_FU*PRF_IDX_W-1:0] fu_tag_i;
  logic [NUM_FU*ROB_IDX_W-1:0] fu_rob_idx_i;
  logic [NUM_FU*BR_MASK_W-1:0] fu_br_mask_i;
  logic [NUM_FU-1:0]           fu_rdy_o;
  logic                        br_pred_correct_i;
  logic                        br_recovery_i;
  logic [BR_MASK_W-1:0]        br_tag_fix_i;
  logic                        cdb_vld_o;
  logic [PRF_IDX_W-1:0]        cdb_tag_o;
  logic [ROB_IDX_W-1:0]        cdb_rob_idx_o;
  logic [BR_MASK_W-1:0]        cdb_br_mask_o;

  modport slave (
    input  fu_vld_i, fu_tag_i, fu_rob_idx_i, fu_br_mask_i,
    input  br_pred_correct_i, br_recovery_i, br_tag_fix_i,
    output fu_rdy_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o
  );

  modport master (
    output fu_vld_i, fu_tag_i, fu_rob_idx_i, fu_br_mask_i,
    output br_pred_correct_i, br_recovery_i, br_tag_fix_i,
    input  fu_rdy_o, cdb_vld_o, cdb_tag_o, cdb_rob_idx_o, cdb_br_mask_o
  );
endinterface

// File: rtl/cdb_bcast.sv
// CDB broadcaster: one holding slot per FU, round-robin grant, branch kill/fix.
// CDB_BYPASS_EN: an idle bus forwards an incoming FU result in the same cycle.
module cdb_bcast_slot #(
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_vld,
  input  logic [PRF_IDX_W-1:0] in_tag,
  input  logic [ROB_IDX_W-1:0] in_rob,
  input  logic [BR_MASK_W-1:0] in_mask,
  input  logic                 br_pred_correct,
  input  logic                 br_recovery,
  input  logic [BR_MASK_W-1:0] br_tag_fix,
  input  logic                 gnt,
  input  logic                 byp,
  output logic                 vld,
  output logic [PRF_IDX_W-1:0] tag,
  output logic [ROB_IDX_W-1:0] rob,
  output logic [BR_MASK_W-1:0] mask_fix,
  output logic                 kill,
  output logic                 rdy,
  output logic                 in_kill,
  output logic [BR_MASK_W-1:0] in_mask_fix
);
  logic [BR_MASK_W-1:0] mask;
  logic                 fix_en, capture;

  // Recovery takes priority over a simultaneous correct-prediction fix.
  assign fix_en      = br_pred_correct & ~br_recovery;
  assign kill        = br_recovery & (|(mask & br_tag_fix));
  assign in_kill     = br_recovery & (|(in_mask & br_tag_fix));
  assign mask_fix    = fix_en ? (mask & ~br_tag_fix) : mask;
  assign in_mask_fix = fix_en ? (in_mask & ~br_tag_fix) : in_mask;
  assign rdy         = ~vld | gnt | kill;
  assign capture     = in_vld & rdy & ~in_kill & ~byp;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      tag  <= '0;
      rob  <= '0;
      mask <= '0;
    end else if (capture) begin
      vld  <= 1'b1;
      tag  <= in_tag;
      rob  <= in_rob;
      mask <= in_mask_fix;
    end else if (rdy) begin
      vld  <= 1'b0;
    end else begin
      mask <= mask_fix;
    end
  end
endmodule

module cdb_bcast #(
  parameter int NUM_FU    = 4,
  parameter int PRF_IDX_W = 6,
  parameter int ROB_IDX_W = 5,
  parameter int BR_MASK_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  cdb_bcast_if.slave  bus
);
  localparam int PTR_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]                s_vld, s_kill, s_rdy, s_gnt, b_gnt, in_kill;
  logic [NUM_FU-1:0]                elig, req, gnt;
  logic [NUM_FU-1:0][PRF_IDX_W-1:0] s_tag;
  logic [NUM_FU-1:0][ROB_IDX_W-1:0] s_rob;
  logic [NUM_FU-1:0][BR_MASK_W-1:0] s_mask, in_mask;
  logic [PTR_W-1:0]                 rr_ptr, gnt_idx;
  logic                             any_elig, found;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_slot
    cdb_bcast_slot #(
      .PRF_IDX_W(PRF_IDX_W), .ROB_IDX_W(ROB_IDX_W), .BR_MASK_W(BR_MASK_W)
    ) u_slot (
      .clk            (clk),
      .rst            (rst),
      .in_vld         (bus.fu_vld_i[g]),
      .in_tag         (bus.fu_tag_i[g*PRF_IDX_W +: PRF_IDX_W]),
      .in_rob         (bus.fu_rob_idx_i[g*ROB_IDX_W +: ROB_IDX_W]),
      .in_mask        (bus.fu_br_mask_i[g*BR_MASK_W +: BR_MASK_W]),
      .br_pred_correct(bus.br_pred_correct_i),
      .br_recovery    (bus.br_recovery_i),
      .br_tag_fix     (bus.br_tag_fix_i),
      .gnt            (s_gnt[g]),
      .byp            (b_gnt[g]),
      .vld            (s_vld[g]),
      .tag            (s_tag[g]),
      .rob            (s_rob[g]),
      .mask_fix       (s_mask[g]),
      .kill           (s_kill[g]),
      .rdy            (s_rdy[g]),
      .in_kill        (in_kill[g]),
      .in_mask_fix    (in_mask[g])
    );
  end

  assign elig     = s_vld & ~s_kill;
  assign any_elig = |elig;
  assign s_gnt    = any_elig ? gnt : '0;

`ifdef CDB_BYPASS_EN
  assign req   = any_elig ? elig : (bus.fu_vld_i & ~in_kill);
  assign b_gnt = any_elig ? '0 : gnt;
`else
  logic unused_byp;
  assign unused_byp = ^{in_kill, in_mask};
  assign req        = elig;
  assign b_gnt      = '0;
`endif

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (found)
      rr_ptr <= (gnt_idx == PTR_W'(NUM_FU-1)) ? '0 : gnt_idx + PTR_W'(1);
  end

  always_comb begin
    bus.cdb_tag_o     = '0;
    bus.cdb_rob_idx_o = '0;
    bus.cdb_br_mask_o = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      if (s_gnt[f]) begin
        bus.cdb_tag_o     = s_tag[f];
        bus.cdb_rob_idx_o = s_rob[f];
        bus.cdb_br_mask_o = s_mask[f];
      end
`ifdef CDB_BYPASS_EN
      if (b_gnt[f]) begin
        bus.cdb_tag_o     = bus.fu_tag_i[f*PRF_IDX_W +: PRF_IDX_W];
        bus.cdb_rob_idx_o = bus.fu_rob_idx_i[f*ROB_IDX_W +: ROB_IDX_W];
        bus.cdb_br_mask_o = in_mask[f];
      end
`endif
    end
  end

  assign bus.cdb_vld_o = |gnt;
  assign bus.fu_rdy_o  = s_rdy;
endmodule
